// File: rtl/sn74ls173_ls126_register.sv
// sn74ls173_ls126_register: 8-bit SAP-1 bus register (CLK/CLR clock+async reset, bus_input, L_A_bar load, E_A bus enable, add_sub_output, bus_output tri-state)
module sn74ls173 (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] d,
  input  logic [1:0] g_bar,
  input  logic       m,
  input  logic       n,
  output logic [3:0] q
);
  logic [3:0] q_q, q_d;
  always_comb q_d = ~|g_bar ? d : q_q;
  always_ff @(posedge clk or posedge clr)
    if (clr) q_q <= 4'h0;
    else q_q <= q_d;
  assign q = (m | n) ? 4'bzzzz : q_q;
endmodule

module sn74ls126 (
  input  logic [3:0] a,
  input  logic [3:0] g,
  output logic [3:0] y
);
  for (genvar i = 0; i < 4; i++) begin : g_buf
    assign y[i] = g[i] ? a[i] : 1'bz;
  end
endmodule

module sn74ls173_ls126_register (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] bus_input,
  input  logic       L_A_bar,
  input  logic       E_A,
  output logic [7:0] add_sub_output,
  output logic [7:0] bus_output
);
  sn74ls173 u_lo (.clk(CLK), .clr(CLR), .d(bus_input[3:0]), .g_bar({2{L_A_bar}}),
                  .m(1'b0), .n(1'b0), .q(add_sub_output[3:0]));
  sn74ls173 u_hi (.clk(CLK), .clr(CLR), .d(bus_input[7:4]), .g_bar({2{L_A_bar}}),
                  .m(1'b0), .n(1'b0), .q(add_sub_output[7:4]));
  sn74ls126 u_buf_lo (.a(add_sub_output[3:0]), .g({4{E_A}}), .y(bus_output[3:0]));
  sn74ls126 u_buf_hi (.a(add_sub_output[7:4]), .g({4{E_A}}), .y(bus_output[7:4]));
endmodule

// File: tb/tb_sn74ls173_ls126_register.sv
// tb_sn74ls173_ls126_register: directed bench; released bus is pulled up so Z reads as 8'hFF
module tb_sn74ls173_ls126_register;
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] bus_in = 8'hAC;
  logic       l_a_bar = 1'b0;
  logic       e_a = 1'b0;
  logic [7:0] asu;
  wire  [7:0] bus_w;
  int n_chk = 0;
  int n_pass = 0;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (bus_w[i]);
  end
  sn74ls173_ls126_register dut (
    .CLK(clk), .CLR(clr), .bus_input(bus_in), .L_A_bar(l_a_bar), .E_A(e_a),
    .add_sub_output(asu), .bus_output(bus_w)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", tag, got, exp, $time);
  endtask
  initial begin
    #12 chk("load_asu", asu, 8'hAC);
    chk("load_bus_released", bus_w, 8'hFF);
    #3 e_a = 1'b1;
    #2 chk("drive_bus", bus_w, 8'hAC);
    #3 l_a_bar = 1'b1;
    #10 bus_in = 8'hF1;
    #5 chk("hold_asu", asu, 8'hAC);
    chk("hold_bus", bus_w, 8'hAC);
    #5 l_a_bar = 1'b0;
    #15 chk("reload_asu", asu, 8'hF1);
    chk("reload_bus", bus_w, 8'hF1);
    #5 e_a = 1'b0;
    #5 chk("release_bus", bus_w, 8'hFF);
    chk("release_asu", asu, 8'hF1);
    bus_in = 8'h5A;
    e_a = 1'b1;
    #10 chk("pre_reset_asu", asu, 8'h5A);
    chk("pre_reset_bus", bus_w, 8'h5A);
    #5 clr = 1'b1;
    #2 chk("async_clr_asu", asu, 8'h00);
    chk("async_clr_bus", bus_w, 8'h00);
    #3 bus_in = 8'hFF;
    #10 chk("clr_blocks_load_asu", asu, 8'h00);
    chk("clr_blocks_load_bus", bus_w, 8'h00);
    #5 clr = 1'b0;
    #15 chk("post_clr_load", asu, 8'hFF);
    bus_in = 8'h3C;
    #20 chk("nib_3c_lo", {4'h0, asu[3:0]}, 8'h0C);
    chk("nib_3c_hi", {4'h0, asu[7:4]}, 8'h03);
    chk("nib_3c_bus", bus_w, 8'h3C);
    bus_in = 8'hC3;
    #20 chk("nib_c3_lo", {4'h0, asu[3:0]}, 8'h03);
    chk("nib_c3_hi", {4'h0, asu[7:4]}, 8'h0C);
    l_a_bar = 1'b1;
    bus_in = 8'h00;
    #20 chk("final_hold", asu, 8'hC3);
    e_a = 1'b0;
    #2 chk("final_release", bus_w, 8'hFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
